// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared pipeline types and NOP control-word constants
package arm_pipe_pkg;

    typedef enum logic [0:0] {RUN, MEM_WAIT} hz_state_t;

    // Values the stage registers load when a bubble or flush is requested
    localparam logic [31:0] NOP_INSTR    = 32'hE1A0_0000;
    localparam logic        NOP_WB_EN    = 1'b0;
    localparam logic        NOP_MEM_R_EN = 1'b0;
    localparam logic        NOP_MEM_W_EN = 1'b0;
    localparam logic [3:0]  NOP_EXE_CMD  = 4'b0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer with SRAM wait FSM and perf counters
module pipeline_hazard_controller
    import arm_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             cnt_clr,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             mem_wait,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int            TW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(MEM_TIMEOUT);

    hz_state_t     state;
    logic [TW-1:0] tcount;
    logic [TW-1:0] tnext;
    logic          mem_stall;
    logic          branch_go;
    logic          hazard_go;

    assign tnext = tcount + TW'(1);

    // Priority chain: hazard/branch are only looked at when no mem stall is active
    always_comb begin
        freeze_if     = 1'b0;
        freeze_id     = 1'b0;
        freeze_exe    = 1'b0;
        freeze_mem    = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        mem_wait      = 1'b0;
        mem_stall     = 1'b0;
        branch_go     = 1'b0;
        hazard_go     = 1'b0;
        if (rst) begin
            mem_wait  = (state == MEM_WAIT);
            mem_stall = (state == MEM_WAIT) ? !sram_ready : (mem_req && !sram_ready);
            if (mem_stall) begin
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_exe = 1'b1;
                freeze_mem = 1'b1;
            end else if (branch_taken) begin
                flush_if_id   = 1'b1;
                bubble_id_exe = 1'b1;
                branch_go     = 1'b1;
            end else if (hazard) begin
                freeze_if     = 1'b1;
                freeze_id     = 1'b1;
                bubble_id_exe = 1'b1;
                hazard_go     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            tcount      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state  <= MEM_WAIT;
                        tcount <= TW'(1);
                        if (T_MAX <= TW'(1)) mem_timeout <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (sram_ready) begin
                        state  <= RUN;
                        tcount <= '0;
                    end else begin
                        // Hold at the limit so a long wait cannot wrap the counter
                        if (tcount < T_MAX) tcount <= tnext;
                        if (tnext >= T_MAX) mem_timeout <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (hazard_go),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (branch_go),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (mem_stall | mem_wait),
        .count (memwait_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed and randomized checks of pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, sram_ready = 1'b0, cnt_clr = 1'b0;
    logic freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, bubble_id_exe, mem_wait, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

    int total = 0;
    int bad = 0;

    // reference model: waiting flag, cycles spent stalled on memory, sticky error, counter values
    bit       m_wait;
    int       m_tc;
    bit       m_to;
    int       m_stall, m_flush, m_mw;
    logic [6:0] obs, expv;

    pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .cnt_clr(cnt_clr),
        .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_exe(freeze_exe),
        .freeze_mem(freeze_mem), .flush_if_id(flush_if_id), .bubble_id_exe(bubble_id_exe),
        .mem_wait(mem_wait), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    function automatic logic [6:0] model_ctrl(input logic h, input logic b, input logic mr, input logic sr);
        logic stall;
        stall = m_wait ? !sr : (mr && !sr);
        if (stall)  return {4'b1111, 2'b00, m_wait};
        if (b)      return {4'b0000, 2'b11, m_wait};
        if (h)      return {4'b1100, 2'b01, m_wait};
        return {6'b0, m_wait};
    endfunction

    function automatic void model_reset();
        m_wait = 0; m_tc = 0; m_to = 0; m_stall = 0; m_flush = 0; m_mw = 0;
    endfunction

    function automatic void model_step(input logic h, input logic b, input logic mr, input logic sr, input logic cc);
        bit stall;
        stall = m_wait ? !sr : (mr && !sr);
        if (cc) begin
            m_stall = 0; m_flush = 0; m_mw = 0;
        end else begin
            if (!stall && !b && h) m_stall = sat_inc(m_stall);
            if (!stall && b)       m_flush = sat_inc(m_flush);
            if (stall || m_wait)   m_mw    = sat_inc(m_mw);
        end
        if (stall) begin
            m_tc   = m_wait ? m_tc + 1 : 1;
            m_wait = 1;
            if (m_tc >= TMO) m_to = 1;
        end else begin
            m_wait = 0;
            m_tc   = 0;
        end
    endfunction

    // drives one cycle starting just after a rising edge; captures outputs mid-cycle
    task automatic tick(input logic h, input logic b, input logic mr, input logic sr, input logic cc);
        hazard = h; branch_taken = b; mem_req = mr; sram_ready = sr; cnt_clr = cc;
        @(negedge clk);
        obs  = {freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, bubble_id_exe, mem_wait};
        expv = model_ctrl(h, b, mr, sr);
        @(posedge clk);
        model_step(h, b, mr, sr, cc);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        hazard = 0; branch_taken = 0; mem_req = 0; sram_ready = 0; cnt_clr = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hazard = 1; branch_taken = 1; mem_req = 1; sram_ready = 0;
        #2;
        total++;
        if ({freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, bubble_id_exe, mem_wait, mem_timeout} !== 8'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b%b%b%b want=00000000", freeze_if, freeze_id, freeze_exe,
                     freeze_mem, flush_if_id, bubble_id_exe, mem_wait, mem_timeout);
        end
        @(posedge clk);
        #1;
        total++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== 12'h000) begin
            bad++;
            $display("FAIL reset_cnt got=%h/%h/%h want=0/0/0", stall_cnt, flush_cnt, memwait_cnt);
        end
        do_reset();
    endtask

    task automatic test_hazard();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 0, 0, 0);
            total++;
            if (obs !== 7'b1100010) begin
                bad++;
                $display("FAIL hazard_ctrl cycle=%0d got=%b want=1100010", i, obs);
            end
        end
        total++;
        if (stall_cnt !== 4'd2) begin
            bad++;
            $display("FAIL hazard_stall_cnt got=%0d want=2", stall_cnt);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        tick(1, 1, 0, 0, 0);
        total++;
        if (obs !== 7'b0000110) begin
            bad++;
            $display("FAIL branch_ctrl got=%b want=0000110", obs);
        end
        total++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL branch_cnt got flush=%0d stall=%0d want flush=1 stall=0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 1, (i == 3), 0);
            if (i == 0)      want = 7'b1111000;
            else if (i < 3)  want = 7'b1111001;
            else             want = 7'b0000111;
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL memwait_ctrl cycle=%0d got=%b want=%b", i, obs, want);
            end
        end
        total++;
        if (memwait_cnt !== 4'd4) begin
            bad++;
            $display("FAIL memwait_cnt got=%0d want=4", memwait_cnt);
        end
        tick(0, 0, 0, 0, 0);
        total++;
        if (obs !== 7'b0000000) begin
            bad++;
            $display("FAIL memwait_back_to_run got=%b want=0000000", obs);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            tick(0, 0, 1, 0, 0);
            total++;
            if (mem_timeout !== (i >= TMO)) begin
                bad++;
                $display("FAIL timeout_rise after=%0d got=%b want=%b", i, mem_timeout, (i >= TMO));
            end
        end
        tick(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) tick(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 0);
        total++;
        if (mem_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b want=1", mem_timeout);
        end
        do_reset();
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_reset got=%b want=0", mem_timeout);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0);
        total++;
        if (stall_cnt !== 4'd15) begin
            bad++;
            $display("FAIL sat_stall_cnt got=%0d want=15", stall_cnt);
        end
        tick(1, 0, 0, 0, 1);
        total++;
        if (stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL sat_clear got=%0d want=0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, bubble_id_exe, mem_wait, mem_timeout} !== 8'b0
            || memwait_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_wait got=%b%b%b%b%b%b%b%b cnt=%0d want=00000000 cnt=0", freeze_if, freeze_id,
                     freeze_exe, freeze_mem, flush_if_id, bubble_id_exe, mem_wait, mem_timeout, memwait_cnt);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        tick(0, 0, 0, 0, 0);
        total++;
        if (obs !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_release_ctrl got=%b want=0000000", obs);
        end
    endtask

    task automatic test_random();
        logic h, b, mr, sr, cc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            h  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 2) == 0);
            sr = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 19) == 0);
            tick(h, b, mr, sr, cc);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_ctrl step=%0d got=%b want=%b", i, obs, expv);
            end
            total++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || memwait_cnt !== CW'(m_mw)
                || mem_timeout !== m_to) begin
                bad++;
                $display("FAIL random_state step=%0d got=%0d/%0d/%0d/%b want=%0d/%0d/%0d/%b", i, stall_cnt,
                         flush_cnt, memwait_cnt, mem_timeout, m_stall, m_flush, m_mw, m_to);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hazard();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Consumes the combinational hazard flag from hazard detection, branch_taken from EXE, and the SRAM access handshake from MEM.
- Produces per-stage freeze and flush controls, a multi-cycle memory-wait FSM with timeout, and saturating performance counters.
- Sits in the top-level pipeline between the hazard unit, the stage registers and the SRAM controller.

Parameters:
- MEM_TIMEOUT, 64: MEM_WAIT cycles before mem_timeout is raised.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- hazard  in  1  RAW hazard flag from hazard detection (ID vs EXE/MEM dests)
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_req  in  1  MEM stage holds a load/store (MEM_R_EN | MEM_W_EN)
- sram_ready  in  1  SRAM controller completes the current access this cycle
- cnt_clr  in  1  synchronous clear of all performance counters
- freeze_if  out  1  hold PC and IF/ID register
- freeze_id  out  1  hold ID/EXE register input selection (ID re-decodes)
- freeze_exe  out  1  hold EXE/MEM register
- freeze_mem  out  1  hold MEM/WB register
- flush_if_id  out  1  load NOP into IF/ID
- bubble_id_exe  out  1  load NOP (all WB/MEM enables 0) into ID/EXE
- mem_wait  out  1  FSM in MEM_WAIT state
- mem_timeout  out  1  sticky error, MEM_WAIT exceeded MEM_TIMEOUT
- stall_cnt  out  CNT_W  cycles stalled by hazard
- flush_cnt  out  CNT_W  taken-branch flush events
- memwait_cnt  out  CNT_W  cycles spent frozen on SRAM

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset state: RUN.
- While rst = 0, all control outputs are 0, all counters are 0, mem_timeout is 0 and the timeout counter is 0.
- Control outputs are combinational from state and inputs (zero-latency, same cycle). State, counters and mem_timeout are registered.
- Priority, highest first, is mem stall, then branch, then hazard.
- RUN with mem_req=1 and sram_ready=0:
  - Assert all four freezes. flush_if_id=0, bubble_id_exe=0.
  - Next state MEM_WAIT. Timeout counter loads 1.
  - branch_taken and hazard are ignored this cycle.
- RUN with mem_req=1 and sram_ready=1: the access completes in one cycle and is treated as no mem stall.
- RUN, no mem stall, branch_taken=1:
  - flush_if_id=1 and bubble_id_exe=1. No freezes.
  - hazard is ignored, because the ID instruction is squashed.
  - flush_cnt += 1.
- RUN, no mem stall, no branch, hazard=1:
  - freeze_if=1, freeze_id=1, bubble_id_exe=1. freeze_exe=0, freeze_mem=0.
  - stall_cnt += 1.
- MEM_WAIT with sram_ready=0:
  - All four freezes asserted, mem_wait=1.
  - memwait_cnt += 1. Timeout counter += 1.
  - When the timeout counter reaches MEM_TIMEOUT, set mem_timeout. It stays set until reset; the FSM keeps waiting.
- MEM_WAIT with sram_ready=1:
  - mem_wait=1 and memwait_cnt += 1 this cycle.
  - Freezes deassert this cycle. Outputs are evaluated with RUN rules using mem stall = 0, so a held branch_taken or hazard is serviced in the release cycle.
  - Next state RUN. Timeout counter clears.
- The initial RUN stall-entry cycle also increments memwait_cnt.
- Counters saturate at all-ones and never wrap.
- cnt_clr has priority over increment, and clears in the next cycle.
- Reset mid-MEM_WAIT returns the FSM to RUN asynchronously, and outputs drop to 0 immediately.
- X on hazard or branch_taken while the mem stall is active must not propagate to outputs; these inputs are gated by the priority.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - typedef enum logic [0:0] {RUN, MEM_WAIT} hz_state_t
  - localparam NOP control-word constants used by the stage registers
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, count) is instantiated three times for the performance counters.

Test Plan:
- hazard=1 for 2 cycles in RUN, mem_req=0 -> freeze_if/freeze_id/bubble_id_exe=1 both cycles, freeze_exe=freeze_mem=0, stall_cnt=2.
- hazard=1 and branch_taken=1 same cycle -> flush_if_id=1, bubble_id_exe=1, freeze_if=0, flush_cnt=1, stall_cnt=0.
- mem_req=1, sram_ready=0 for 3 cycles then 1 -> freezes high 3 cycles, low on the ready cycle, mem_wait high cycles 2–4, memwait_cnt=4, state back to RUN.
- MEM_TIMEOUT=4, mem_req=1, sram_ready held 0 for 6 cycles -> mem_timeout rises when the timeout counter reaches 4, stays 1 after ready and after further traffic until rst=0.
- Saturation with CNT_W=4: 20 hazard cycles -> stall_cnt=15. Then cnt_clr=1 together with hazard=1 -> stall_cnt=0 next cycle.
- rst asserted low mid-MEM_WAIT -> all outputs 0 immediately, state RUN. After release with mem_req=0, no freezes are asserted.
